// File: rtl/spi_arbiter.sv
// spi_arbiter -- round-robin arbiter sharing one SPI master among REQUESTERS
// clients. A winner's frame and chip-select index are latched and handed to
// the master with a send strobe. The arbiter then waits for the master to
// go busy (ready low) and then idle again (ready high). At that point the
// received frame is captured and the winner gets a one-cycle done pulse.
// If the master never starts within TIMEOUT cycles, the transfer is dropped
// and a timeout pulse is issued.
//
// Ports:
//   clk_in, reset_in      clock, synchronous active-high reset
//   req_in                per-requester level request
//   data_in / cs_in       packed per-requester TX frame / chip-select index
//   r_grant_out           one-hot grant, held START..DONE
//   r_done_out            one-cycle completion pulse to the owner
//   r_timeout_out         one-cycle pulse when the master never started
//   r_data_out            last received frame
//   r_spi_data_out/_cs_out/_send_out   request to the SPI master
//   spi_ready_in, spi_data_in          master idle flag / receive frame
module spi_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int SIZE       = 40,
  parameter int CS_WIDTH   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic [REQUESTERS-1:0]          req_in,
  input  logic [REQUESTERS*SIZE-1:0]     data_in,
  input  logic [REQUESTERS*CS_WIDTH-1:0] cs_in,
  output logic [REQUESTERS-1:0]          r_grant_out,
  output logic [REQUESTERS-1:0]          r_done_out,
  output logic                           r_timeout_out,
  output logic [SIZE-1:0]                r_data_out,
  output logic [SIZE-1:0]                r_spi_data_out,
  output logic [CS_WIDTH-1:0]            r_spi_cs_out,
  output logic                           r_spi_send_out,
  input  logic                           spi_ready_in,
  input  logic [SIZE-1:0]                spi_data_in
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [REQUESTERS-1:0] ONE = REQUESTERS'(1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        last_q, cur_q, win_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [REQUESTERS-1:0]   grant_q, done_q;
  logic                    timeout_q, send_q;
  logic [SIZE-1:0]         rdata_q, sdata_q;
  logic [CS_WIDTH-1:0]     cs_q;

  // Unpacked views of the flat per-requester buses
  logic [REQUESTERS-1:0][SIZE-1:0]     data_arr;
  logic [REQUESTERS-1:0][CS_WIDTH-1:0] cs_arr;

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
    assign data_arr[g] = data_in[g*SIZE +: SIZE];
    assign cs_arr[g]   = cs_in[g*CS_WIDTH +: CS_WIDTH];
  end

  // Round-robin pick: scan last+1 .. last+REQUESTERS (mod REQUESTERS), so
  // the previous owner is examined last and has the lowest priority.
  always_comb begin
    logic             found;
    int               j;
    logic [IDX_W-1:0] jj;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    win_d = last_q;
    for (int i = 1; i <= REQUESTERS; i++) begin
      j  = (int'(last_q) + i) % REQUESTERS;
      jj = IDX_W'(j);
      if (!found && req_in[jj]) begin
        found = 1'b1;
        win_d = jj;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(REQUESTERS - 1);
      cur_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      send_q    <= 1'b0;
      rdata_q   <= '0;
      sdata_q   <= '0;
      cs_q      <= '0;
    end else begin
      // Pulses default low; only the transitions below raise them
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_in && spi_ready_in) begin
            state_q <= START;
            cur_q   <= win_d;
            grant_q <= ONE << win_d;
            send_q  <= 1'b1;
            sdata_q <= data_arr[win_d];
            cs_q    <= cs_arr[win_d];
            cnt_q   <= '0;
          end
        end
        START: begin
          if (!spi_ready_in) begin
            state_q <= BUSY;
            send_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Master never picked up the frame: abandon, rotate past owner
            state_q   <= IDLE;
            send_q    <= 1'b0;
            grant_q   <= '0;
            timeout_q <= 1'b1;
            last_q    <= cur_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BUSY: begin
          if (spi_ready_in) begin
            state_q <= DONE;
            rdata_q <= spi_data_in;
            done_q  <= grant_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          last_q  <= cur_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_grant_out    = grant_q;
  assign r_done_out     = done_q;
  assign r_timeout_out  = timeout_q;
  assign r_data_out     = rdata_q;
  assign r_spi_data_out = sdata_q;
  assign r_spi_cs_out   = cs_q;
  assign r_spi_send_out = send_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter -- transfer-level reference model of the arbiter plus a
// small SPI master model, directed scenarios, then randomized traffic.
module tb_spi_arbiter;
  localparam int R  = 4;
  localparam int SZ = 40;
  localparam int CW = 4;
  localparam int TO = 64;

  logic            clk_in = 1'b0;
  logic            reset_in = 1'b1;
  logic [R-1:0]    req_in = '0;
  logic [R*SZ-1:0] data_in = '0;
  logic [R*CW-1:0] cs_in = '0;
  logic            spi_ready_in;
  logic [SZ-1:0]   spi_data_in;
  logic [R-1:0]    r_grant_out, r_done_out;
  logic            r_timeout_out, r_spi_send_out;
  logic [SZ-1:0]   r_data_out, r_spi_data_out;
  logic [CW-1:0]   r_spi_cs_out;

  spi_arbiter #(.REQUESTERS(R), .SIZE(SZ), .CS_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .data_in(data_in),
    .cs_in(cs_in), .r_grant_out(r_grant_out), .r_done_out(r_done_out),
    .r_timeout_out(r_timeout_out), .r_data_out(r_data_out),
    .r_spi_data_out(r_spi_data_out), .r_spi_cs_out(r_spi_cs_out),
    .r_spi_send_out(r_spi_send_out), .spi_ready_in(spi_ready_in),
    .spi_data_in(spi_data_in));

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transfer level) ----------------
  int            m_last = R - 1;
  int            m_owner = -1;   // -1: no transfer in flight
  int            m_wait = 0;     // cycles the master has left the frame untouched
  bit            m_started = 0;  // master has gone busy on this frame
  bit            m_finished = 0; // completion reported, owner released next edge
  logic [R-1:0]  e_done = '0;
  bit            e_to = 0;
  logic [SZ-1:0] e_sdata = '0, e_rdata = '0;
  logic [CW-1:0] e_cs = '0;
  bit            chk_en = 0;

  function automatic int rr(input int last, input logic [R-1:0] req);
    for (int i = 1; i <= R; i++)
      if (req[(last + i) % R]) return (last + i) % R;
    return -1;
  endfunction

  // monitors used by directed checks
  int         glog[$];
  logic [R-1:0] prev_g = '0;
  int         run = 0, last_run = 0, to_cnt = 0, done_cnt = 0;

  always begin
    @(posedge clk_in);
    e_done = '0;
    e_to   = 0;
    if (reset_in) begin
      m_owner = -1; m_last = R - 1; m_started = 0; m_finished = 0;
      e_sdata = '0; e_rdata = '0; e_cs = '0; chk_en = 1;
    end else if (m_owner < 0) begin
      if (req_in != 0 && spi_ready_in) begin
        m_owner = rr(m_last, req_in);
        m_started = 0; m_finished = 0; m_wait = 0;
        e_sdata = data_in[m_owner*SZ +: SZ];
        e_cs    = cs_in[m_owner*CW +: CW];
      end
    end else if (m_finished) begin
      m_last = m_owner; m_owner = -1;
    end else if (!m_started) begin
      if (!spi_ready_in) m_started = 1;
      else if (m_wait == TO - 1) begin
        e_to = 1; m_last = m_owner; m_owner = -1;
      end else m_wait++;
    end else if (spi_ready_in) begin
      m_finished = 1;
      e_done[m_owner] = 1'b1;
      e_rdata = spi_data_in;
    end

    @(negedge clk_in);
    if (chk_en) begin
      chk("grant", r_grant_out, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
      chk("send", r_spi_send_out, (m_owner >= 0) && !m_started);
      chk("done", r_done_out, e_done);
      chk("timeout", r_timeout_out, e_to);
      chk("rx_data", r_data_out, e_rdata);
      chk("spi_data", r_spi_data_out, e_sdata);
      chk("spi_cs", r_spi_cs_out, e_cs);
    end
    if (r_grant_out != 0 && prev_g == 0)
      for (int k = 0; k < R; k++) if (r_grant_out[k]) glog.push_back(k);
    prev_g = r_grant_out;
    if (r_spi_send_out === 1'b1) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (r_timeout_out === 1'b1) to_cnt++;
    if (r_done_out != 0) done_cnt++;
  end

  // ---------------- SPI master model ----------------
  int            mode = 0;      // 0 normal, 1 stuck idle, 2 stuck busy
  bit            rand_mst = 0;
  int            m_dly = 1, m_busy = 10, mst_st = 0, mst_cnt = 0;
  logic [SZ-1:0] m_rx = '0;

  initial begin
    spi_ready_in = 1'b1;
    spi_data_in  = '0;
    forever begin
      @(posedge clk_in); #2;
      if (reset_in) begin
        mst_st = 0; spi_ready_in = 1'b1;
      end else if (mode == 1) spi_ready_in = 1'b1;
      else if (mode == 2) spi_ready_in = 1'b0;
      else case (mst_st)
        0: begin
          spi_ready_in = 1'b1;
          if (r_spi_send_out) begin
            if (rand_mst) begin
              m_dly  = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 3));
              m_busy = $urandom_range(0, 8);
            end
            mst_st = 1; mst_cnt = m_dly;
          end
        end
        1: if (mst_cnt == 0) begin
             spi_ready_in = 1'b0; mst_st = 2; mst_cnt = m_busy;
           end else mst_cnt--;
        default: if (mst_cnt == 0) begin
             spi_ready_in = 1'b1; spi_data_in = m_rx; mst_st = 0;
             if (rand_mst) m_rx = SZ'({$urandom(), $urandom()});
           end else mst_cnt--;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit cond(input int c);
    case (c)
      0:       return r_done_out != 0;
      1:       return r_timeout_out === 1'b1;
      default: return r_grant_out != 0 && r_spi_send_out === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int c, input int budget, input string name);
    int n = 0;
    while (1) begin
      @(negedge clk_in); #2;
      if (cond(c)) break;
      if (++n > budget) begin
        vectors++; errors++;
        $display("FAIL wait_%s: no event within %0d cycles", name, budget);
        break;
      end
    end
  endtask

  task automatic rst();
    @(posedge clk_in); #1 reset_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in); #1 reset_in = 1'b0;
  endtask

  initial begin
    int snap;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;
    @(negedge clk_in);
    chk("rst_grant", r_grant_out, 0);
    chk("rst_send", r_spi_send_out, 0);
    chk("rst_data", r_data_out, 0);
    chk("rst_cs", r_spi_cs_out, 0);
    #2;

    // single request on requester 2
    for (int k = 0; k < R; k++) begin
      data_in[k*SZ +: SZ] = SZ'({$urandom(), $urandom()});
      cs_in[k*CW +: CW]   = CW'($urandom());
    end
    data_in[2*SZ +: SZ] = 40'hAB_CDEF0123;
    cs_in[2*CW +: CW]   = 4'h5;
    m_rx = 40'h12_34567890; m_dly = 1; m_busy = 10;
    req_in = 4'b0100;
    wait_for(0, 100, "t1_done");
    chk("t1_done", r_done_out, 4'b0100);
    chk("t1_cs", r_spi_cs_out, 4'h5);
    chk("t1_sdata", r_spi_data_out, 40'hAB_CDEF0123);
    chk("t1_rdata", r_data_out, 40'h12_34567890);
    chk("t1_first_grant", glog.size() > 0 ? glog[0] : -1, 2);
    req_in = '0;
    @(negedge clk_in);
    chk("t1_done_one_cycle", r_done_out, 0);

    // fairness with everybody requesting
    rst();
    glog.delete();
    m_dly = 0; m_busy = 2;
    req_in = 4'b1111;
    repeat (8) wait_for(0, 100, "t2_done");
    req_in = '0;
    for (int i = 0; i < 8; i++)
      chk("t2_order", glog.size() > i ? glog[i] : -1, i % 4);

    // timeout with a master that never goes busy
    glog.delete(); to_cnt = 0;
    mode = 1;
    req_in = 4'b0011;
    wait_for(1, 200, "t3_timeout");
    mode = 0;
    chk("t3_send_len", last_run, 64);
    chk("t3_grant_clr", r_grant_out, 0);
    wait_for(0, 100, "t3_done");
    req_in = '0;
    chk("t3_to_cnt", to_cnt, 1);
    chk("t3_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t3_next", glog.size() > 1 ? glog[1] : -1, 1);

    // master busy in IDLE holds off the grant
    rst();
    mode = 2;
    req_in = 4'b0001;
    repeat (10) begin
      @(negedge clk_in);
      chk("t4_nogrant", r_grant_out, 0);
    end
    #2 mode = 0;
    @(negedge clk_in);
    chk("t4_still_none", r_grant_out, 0);
    @(negedge clk_in);
    chk("t4_grant", r_grant_out, 4'b0001);
    wait_for(0, 100, "t4_done");
    req_in = '0;

    // reset while the master is busy
    m_dly = 0; m_busy = 10;
    req_in = 4'b0100;
    wait_for(2, 100, "t5_busy");
    @(posedge clk_in); #1 reset_in = 1'b1; req_in = '0;
    @(posedge clk_in); #1 reset_in = 1'b0;
    @(negedge clk_in);
    chk("t5_grant", r_grant_out, 0);
    chk("t5_send", r_spi_send_out, 0);
    chk("t5_done", r_done_out, 0);
    chk("t5_sdata", r_spi_data_out, 0);
    chk("t5_cs", r_spi_cs_out, 0);
    chk("t5_rdata", r_data_out, 0);
    snap = done_cnt;
    repeat (15) @(negedge clk_in);
    chk("t5_no_done", done_cnt, snap);
    #2 glog.delete();
    m_busy = 3;
    req_in = 4'b1111;
    wait_for(0, 100, "t5_done");
    req_in = '0;
    chk("t5_next", glog.size() > 0 ? glog[0] : -1, 0);

    // requester drops its request mid transfer
    rst();
    req_in = 4'b0010;
    wait_for(2, 100, "t6_busy");
    req_in = '0;
    wait_for(0, 100, "t6_done");
    chk("t6_done", r_done_out, 4'b0010);
    repeat (10) begin
      @(negedge clk_in);
      chk("t6_no_regrant", r_grant_out, 0);
    end

    // randomized traffic, checked cycle by cycle against the model
    rand_mst = 1;
    repeat (1500) begin
      @(posedge clk_in); #1;
      reset_in = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) req_in = R'($urandom());
      for (int k = 0; k < R; k++) begin
        data_in[k*SZ +: SZ] = SZ'({$urandom(), $urandom()});
        cs_in[k*CW +: CW]   = CW'($urandom());
      end
    end
    reset_in = 1'b0;
    req_in = '0;
    repeat (150) @(posedge clk_in);
    @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
